instruction_loader: RTL
=======================

// Module: instruction_loader
// PURPOSE
//  Byte-stream loader that writes a program into the writable instruction RAM.
//  Receives a length header plus big-endian instruction words from the host link.
//  Drives the RAM write port at consecutive word addresses.
//  Holds the MIPS core in reset while loading; fetch then starts from word 0.
// PARAMETERS
//  DEPTH      128        instruction RAM size in 32-bit words
//  ADDR_W     7          word-address width (fetch uses Address[ADDR_W+1:2])
//  TIMEOUT    1000000    max idle cycles between bytes before abort
// PORTS
//  Clk        in   1       system clock
//  Reset      in   1       synchronous, active-high reset
//  Start      in   1       1-cycle pulse: begin a new load
//  RxData     in   8       incoming byte
//  RxValid    in   1       1-cycle strobe: RxData valid this cycle
//  WrEn       out  1       RAM write enable, 1-cycle pulse per word
//  WrAddr     out  ADDR_W  RAM word address
//  WrData     out  32      RAM write data
//  CpuHold    out  1       core held in reset while high
//  Busy       out  1       load in progress
//  Done       out  1       load completed OK; level, cleared by next Start
//  Error      out  1       load aborted; level, cleared by next Start
//  WordCount  out  16      words written in the current or last load
// BEHAVIOUR
//  - Reset: state IDLE; every output 0, including CpuHold; counters cleared.
//  - States: IDLE, LEN_HI, LEN_LO, DATA, CHECK (macro only), DONE, ERROR.
//  - IDLE/DONE/ERROR + Start -> LEN_HI. Done, Error, WordCount cleared.
//    CpuHold=1 and Busy=1 from the next cycle.
//  - Start while Busy: ignored. RxValid in IDLE/DONE/ERROR: ignored.
//  - LEN_HI: byte -> N[15:8]. LEN_LO: byte -> N[7:0], then:
//    N>DEPTH -> ERROR. N==0 -> DONE (or CHECK). Else -> DATA.
//  - DATA: bytes shifted in MSB first. The 4th byte completes a word.
//    WrEn=1 exactly one cycle after that byte's RxValid cycle.
//    WrAddr=word index (first word 0). WrData=assembled word.
//    WordCount increments with WrEn.
//  - After word N-1 is written -> DONE (or CHECK).
//  - Back-to-back RxValid on every cycle is supported with no byte loss.
//  - WrAddr/WrData hold their last values when WrEn=0.
//  - DONE: Done=1, Busy=0, CpuHold=0 one cycle after the final WrEn.
//  - ERROR: Error=1, Busy=0, CpuHold stays 1 (core never runs a partial image).
//  - Timeout: idle counter clears on every RxValid and counts while Busy.
//    Reaching TIMEOUT -> ERROR. No WrEn is issued after the abort.
//  - Reset mid-load: immediate return to IDLE, CpuHold=0.
//    RAM contents already written are left as they are.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   - One trailer byte follows the data. It equals the XOR of all header and data bytes.
//   - CHECK state: on that byte, match -> DONE, mismatch -> ERROR.
//   - Timeout applies in CHECK.
//  LOADER_CHECKSUM_EN undefined:
//   - No CHECK state. DONE directly after the last word (or after N==0).
// TESTING
//  - Reset, Start, bytes 00 02 20 09 00 02 20 0A 00 03 ->
//    WrEn@0=0x20090002, WrEn@1=0x200A0003, Done=1, WordCount=2, CpuHold=0.
//  - Header 00 81 (N=129 > DEPTH) -> Error=1, no WrEn, CpuHold=1.
//  - Header 00 00 -> Done=1, WordCount=0, no WrEn (checksum byte 00 if macro on).
//  - N=1, two data bytes, then TIMEOUT idle cycles -> Error=1, no WrEn.
//  - Reset asserted after 2 of 3 words -> all outputs 0; a new Start reloads from addr 0.
//  - Macro on: N=1, word 0xFFFFFFFF, checksum 01 -> Done.
//    Same stream with checksum 00 -> Error (WrEn@0 still issued).

Source files
------------

// File: rtl/instruction_loader.sv
// Byte-stream program loader for the instruction RAM: length header, big-endian words, core held in reset.
// Optional trailer-checksum verification is enabled by defining LOADER_CHECKSUM_EN.
`default_nettype none

module instruction_loader #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 1000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [31:0]       WrData,
  output logic              CpuHold,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [15:0]       WordCount
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR} state_t;
`endif

  state_t             state, state_nxt;
  logic [15:0]        len_q;
  logic [1:0]         byte_cnt;
  logic [23:0]        shift_q;
  logic [TMR_W-1:0]   idle_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  logic        busy_w;
  logic        start_go;
  logic        timed_out;
  logic        words_done;
  logic        data_take;
  logic        word_last;
  logic [15:0] len_n;

  assign busy_w     = (state == LEN_HI) || (state == LEN_LO) || (state == DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state == CHECK)
`endif
                      ;
  assign start_go   = Start && !busy_w;
  assign timed_out  = busy_w && !RxValid && (idle_cnt == TMR_W'(TIMEOUT - 1));
  assign words_done = (WordCount == len_q);
  // Bytes arriving after the last word (before DONE is entered) are not part of the image.
  assign data_take  = (state == DATA) && RxValid && !words_done;
  assign word_last  = data_take && (byte_cnt == 2'd3);
  assign len_n      = {len_q[15:8], RxData};

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (Start) state_nxt = LEN_HI;
      LEN_HI:            if (RxValid) state_nxt = LEN_LO;
      LEN_LO: begin
        if (RxValid) begin
          if (len_n > 16'(DEPTH)) state_nxt = ERROR;
`ifdef LOADER_CHECKSUM_EN
          else if (len_n == 16'd0) state_nxt = CHECK;
`else
          else if (len_n == 16'd0) state_nxt = DONE;
`endif
          else state_nxt = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      // The trailer byte may follow the last data byte back-to-back, so leave DATA on that byte.
      DATA:  if (word_last && (16'(WordCount + 16'd1) == len_q)) state_nxt = CHECK;
      CHECK: if (RxValid) state_nxt = (RxData == csum) ? DONE : ERROR;
`else
      // WordCount has caught up during the final WrEn cycle, so DONE lands one cycle later.
      DATA:  if (words_done) state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (timed_out) state_nxt = ERROR;
  end

  // Moore outputs: the core stays held after an abort so a partial image never runs.
  always_comb begin
    Busy    = busy_w;
    CpuHold = busy_w || (state == ERROR);
    Done    = (state == DONE);
    Error   = (state == ERROR);
  end

  // Datapath: length capture, word assembly, write port, idle timer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      len_q     <= '0;
      byte_cnt  <= '0;
      shift_q   <= '0;
      idle_cnt  <= '0;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
      WordCount <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      WrEn <= 1'b0;

      if (start_go) begin
        len_q     <= '0;
        byte_cnt  <= '0;
        idle_cnt  <= '0;
        WordCount <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum      <= '0;
`endif
      end else if (busy_w) begin
        idle_cnt <= RxValid ? '0 : idle_cnt + 1'b1;
      end

      if (state == LEN_HI && RxValid) len_q[15:8] <= RxData;
      if (state == LEN_LO && RxValid) len_q[7:0]  <= RxData;

`ifdef LOADER_CHECKSUM_EN
      if ((state == LEN_HI || state == LEN_LO) && RxValid) csum <= csum ^ RxData;
      if (data_take) csum <= csum ^ RxData;
`endif

      if (data_take) begin
        shift_q  <= {shift_q[15:0], RxData};
        byte_cnt <= byte_cnt + 2'd1;
      end

      if (word_last) begin
        WrEn      <= 1'b1;
        WrAddr    <= WordCount[ADDR_W-1:0];
        WrData    <= {shift_q, RxData};
        WordCount <= WordCount + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
